// File: rtl/mux_rr_arb_pkg.sv
// mux_rr_arb_pkg: constants and helpers shared by the round-robin mux, its arbiter and mux2.
// Latency: n/a (types, constants and elaboration-time functions only).
// Backpressure: n/a.
package mux_rr_arb_pkg;

  // Default per-channel data width, shared with mux2.
  localparam int DATA_W = 16;

  // Default channel count.
  localparam int N_CH = 4;

  // Ceiling log2 used for derived index widths; returns at least 1 so a
  // channel index is never zero bits wide.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_rr_arb_arbiter.sv
// rr_arbiter: combinational round-robin grant, searching upward from ptr and wrapping n-1 -> 0.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller qualifies the grant with its own load condition.
// Ports: req[n] request vector, ptr[chw] highest-priority index,
//        gnt_idx[chw] granted index (0 when nothing is granted), gnt_valid some request granted.
module rr_arbiter
  import mux_rr_arb_pkg::*;
#(
  parameter int n   = N_CH,
  parameter int chw = clog2(n)
) (
  input  logic [n-1:0]   req,
  input  logic [chw-1:0] ptr,
  output logic [chw-1:0] gnt_idx,
  output logic           gnt_valid
);

  int start;

  always_comb begin
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    // An out-of-range pointer (only reachable for non power-of-two n) falls back to 0.
    start     = (int'(ptr) < n) ? int'(ptr) : 0;
    for (int k = 0; k < n; k++) begin
      int idx;
      idx = start + k;
      if (idx >= n) idx = idx - n;
      if (!gnt_valid && req[chw'(idx)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = chw'(idx);
      end
    end
  end

endmodule

// File: rtl/mux_rr_arb.sv
// mux_rr_arb: n-channel valid/ready mux with round-robin arbitration into one registered output stage.
// Latency: 1 cycle input-to-output; 1 beat/cycle throughput, drain and refill in the same cycle.
// Backpressure: out_valid & ~out_ready holds the beat and drops every in_ready; rst_n=0 also drops in_ready.
// Ports: in_data/in_valid/in_ready per-channel request side (channel i at [i*size +: size]),
//        out_data/out_chan/out_valid/out_ready registered consumer side, clk/rst_n synchronous reset.
module mux_rr_arb
  import mux_rr_arb_pkg::*;
#(
  parameter int size = DATA_W,
  parameter int n    = N_CH,
  parameter int chw  = clog2(n)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [n*size-1:0] in_data,
  input  logic [n-1:0]    in_valid,
  output logic [n-1:0]    in_ready,
  output logic [size-1:0] out_data,
  output logic [chw-1:0]  out_chan,
  output logic            out_valid,
  input  logic            out_ready
);

  logic            out_valid_q, out_valid_d;
  logic [size-1:0] out_data_q, out_data_d;
  logic [chw-1:0]  out_chan_q, out_chan_d;
  logic [chw-1:0]  ptr_q, ptr_d;

  logic [chw-1:0]  gnt_idx;
  logic            gnt_valid;
  logic            load;
  logic            xfer;

  rr_arbiter #(
    .n   (n),
    .chw (chw)
  ) u_arb (
    .req       (in_valid),
    .ptr       (ptr_q),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  always_comb begin
    load        = ~out_valid_q | out_ready;
    // The granted channel is valid by construction, so this is exactly in_valid & in_ready.
    xfer        = rst_n & load & gnt_valid;
    in_ready    = '0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      in_ready[gnt_idx] = 1'b1;
      // A refill overrides any simultaneous drain, so valid stays high with no bubble.
      out_valid_d = 1'b1;
      out_data_d  = in_data[int'(gnt_idx)*size +: size];
      out_chan_d  = gnt_idx;
      ptr_d       = (gnt_idx == chw'(n - 1)) ? '0 : chw'(gnt_idx + 1'b1);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_mux_rr_arb.sv
// tb_mux_rr_arb: directed vector table on an n=4/size=16 instance plus a randomised n=5/size=32 scoreboard run.
// Latency: n/a (testbench).
// Backpressure: the bench drives out_ready directly to exercise stall, drain and refill.
module tb_mux_rr_arb;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int SN = 5;
  localparam int SW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // n=4, size=16 instance
  logic           rst_n;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic [1:0]     out_chan;
  logic           out_valid;
  logic           out_ready;

  mux_rr_arb #(.size(W), .n(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // n=5, size=32 instance
  logic             s_rst_n;
  logic [SN*SW-1:0] s_in_data;
  logic [SN-1:0]    s_in_valid;
  logic [SN-1:0]    s_in_ready;
  logic [SW-1:0]    s_out_data;
  logic [2:0]       s_out_chan;
  logic             s_out_valid;
  logic             s_out_ready;

  mux_rr_arb #(.size(SW), .n(SN)) dut5 (
    .clk       (clk),
    .rst_n     (s_rst_n),
    .in_data   (s_in_data),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .out_data  (s_out_data),
    .out_chan  (s_out_chan),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst_n;
    logic [3:0]  vld;
    logic        ordy;
    logic [63:0] dat;
    logic [3:0]  exp_rdy;
    logic        exp_vld;
    logic [1:0]  exp_chan;
    logic [15:0] exp_dat;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [3:0] v, input logic o, input logic [63:0] d,
                     input logic [3:0] er, input logic ev, input logic [1:0] ec, input logic [15:0] ed);
    vec_t t;
    t.rst_n = r; t.vld = v; t.ordy = o; t.dat = d;
    t.exp_rdy = er; t.exp_vld = ev; t.exp_chan = ec; t.exp_dat = ed;
    vecs.push_back(t);
  endtask

  localparam logic [63:0] D1 = 64'h00A3_BEEF_00A1_00A0;
  localparam logic [63:0] D2 = 64'h00A3_00A2_00A1_00A0;

  int tx_seq[SN];
  int rx_seq[SN];
  int waits[SN];

  initial begin
    rst_n = 1'b0; in_valid = '0; out_ready = 1'b0; in_data = '0;
    s_rst_n = 1'b0; s_in_valid = '0; s_out_ready = 1'b0; s_in_data = '0;

    // Reset: in_ready must be forced low even with requests present.
    add(1'b0, 4'b0000, 1'b1, D1, 4'b0000, 1'b0, 2'd0, 16'h0000);
    add(1'b0, 4'b1111, 1'b1, D1, 4'b0000, 1'b0, 2'd0, 16'h0000);
    // Idle: nothing moves, pointer stays put.
    for (int k = 0; k < 10; k++) add(1'b1, 4'b0000, 1'b1, D1, 4'b0000, 1'b0, 2'd0, 16'h0000);
    // Single channel 2, then drain holds data/chan.
    add(1'b1, 4'b0100, 1'b1, D1, 4'b0100, 1'b1, 2'd2, 16'hBEEF);
    add(1'b1, 4'b0000, 1'b1, D1, 4'b0000, 1'b0, 2'd2, 16'hBEEF);
    // ptr is now 3: with ch0 and ch3 requesting, ch3 wins.
    add(1'b1, 4'b1001, 1'b1, D1, 4'b1000, 1'b1, 2'd3, 16'h00A3);
    // Full contention from ptr=0: 0,1,2,3,0,1,2,3 back to back.
    for (int k = 0; k < 8; k++)
      add(1'b1, 4'b1111, 1'b1, D2, 4'(1 << (k % 4)), 1'b1, 2'(k % 4), 16'h00A0 + 16'(k % 4));
    // Backpressure with a ch1 beat held, then drain+refill from ch2.
    add(1'b1, 4'b0010, 1'b1, D2, 4'b0010, 1'b1, 2'd1, 16'h00A1);
    for (int k = 0; k < 3; k++) add(1'b1, 4'b1111, 1'b0, D2, 4'b0000, 1'b1, 2'd1, 16'h00A1);
    add(1'b1, 4'b1111, 1'b1, D2, 4'b0100, 1'b1, 2'd2, 16'h00A2);
    // Reset mid-operation (beat held, ptr=3, backpressured); first grant after is ch0.
    add(1'b0, 4'b1111, 1'b0, D2, 4'b0000, 1'b0, 2'd0, 16'h0000);
    add(1'b1, 4'b1111, 1'b1, D2, 4'b0001, 1'b1, 2'd0, 16'h00A0);
    add(1'b1, 4'b1111, 1'b1, D2, 4'b0010, 1'b1, 2'd1, 16'h00A1);

    @(posedge clk); #1;
    for (int i = 0; i < vecs.size(); i++) begin
      rst_n     = vecs[i].rst_n;
      in_valid  = vecs[i].vld;
      out_ready = vecs[i].ordy;
      in_data   = vecs[i].dat;
      @(negedge clk);
      chk($sformatf("v%0d in_ready", i), 64'(in_ready), 64'(vecs[i].exp_rdy));
      @(posedge clk); #1;
      chk($sformatf("v%0d out_valid", i), 64'(out_valid), 64'(vecs[i].exp_vld));
      chk($sformatf("v%0d out_chan", i), 64'(out_chan), 64'(vecs[i].exp_chan));
      chk($sformatf("v%0d out_data", i), 64'(out_data), 64'(vecs[i].exp_dat));
    end
    in_valid = '0;

    // Randomised run on n=5: each channel offers tagged beats {chan, seq} and holds
    // valid until accepted; the scoreboard checks order, loss/duplication and wait bound.
    for (int c = 0; c < SN; c++) begin tx_seq[c] = 0; rx_seq[c] = 0; waits[c] = 0; end
    repeat (2) @(posedge clk);
    #1 s_rst_n = 1'b1;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      int g;
      for (int c = 0; c < SN; c++) begin
        if (!s_in_valid[c]) s_in_valid[c] = ($urandom_range(0, 2) != 0);
        s_in_data[c*SW +: SW] = {8'(c), 24'(tx_seq[c])};
      end
      s_out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      chk("sw in_ready legal", 64'($onehot0(s_in_ready) && ((s_in_ready & ~s_in_valid) == '0)), 64'd1);
      if (s_out_valid && s_out_ready) begin
        if (s_out_chan < 3'(SN)) begin
          chk("sw out_data", 64'(s_out_data), 64'({8'(s_out_chan), 24'(rx_seq[s_out_chan])}));
          rx_seq[s_out_chan]++;
        end else begin
          chk("sw out_chan range", 64'(s_out_chan), 64'(SN - 1));
        end
      end
      g = -1;
      for (int c = 0; c < SN; c++) if (s_in_valid[c] && s_in_ready[c]) g = c;
      if (g >= 0) begin
        tx_seq[g]++;
        waits[g] = 0;
        for (int c = 0; c < SN; c++) begin
          if (c != g && s_in_valid[c]) begin
            waits[c]++;
            if (waits[c] > SN - 1) chk($sformatf("sw wait ch%0d", c), 64'(waits[c]), 64'(SN - 1));
          end
        end
      end
      @(posedge clk); #1;
      if (g >= 0) s_in_valid[g] = 1'b0;
    end
    // Drain whatever is still held in the output register.
    s_in_valid = '0;
    s_out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (s_out_valid && s_out_chan < 3'(SN)) begin
        chk("sw drain data", 64'(s_out_data), 64'({8'(s_out_chan), 24'(rx_seq[s_out_chan])}));
        rx_seq[s_out_chan]++;
      end
      @(posedge clk); #1;
    end
    for (int c = 0; c < SN; c++) begin
      chk($sformatf("sw count ch%0d", c), 64'(rx_seq[c]), 64'(tx_seq[c]));
      chk($sformatf("sw traffic ch%0d", c), 64'(tx_seq[c] > 100), 64'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_rr_arb.md
Name: mux_rr_arb

Overview:
- N-channel successor to the 2:1 data mux: selects one of n valid/ready input channels with a round-robin arbiter instead of an external select.
- Drives one registered output stage with a valid/ready handshake. Latency is 1 cycle and throughput is 1 beat/cycle.
- Sits between multiple requesters (e.g. fetch and load/store paths) and a single shared consumer such as the memory port or writeback bus.

Parameters:
- size, 16, data width per channel in bits
- n, 4, number of input channels; legal range 2..16
- chw, $clog2(n), channel-index width; derived, do not override

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- in_data  input  n*size  packed channel data; channel i occupies [i*size +: size]
- in_valid  input  n  per-channel request
- in_ready  output  n  per-channel accept; at most one bit set
- out_data  output  size  registered selected data
- out_chan  output  chw  registered index of the channel that supplied out_data
- out_valid  output  1  output register holds a beat
- out_ready  input  1  consumer accepts the beat

Behaviour:
- Reset: when rst_n=0 at a clk edge, the following take effect after that edge:
  - out_valid=0, out_data=0, out_chan=0, priority pointer ptr=0.
  - Any beat held in the output register is discarded.
  - in_ready is forced to 0 combinationally while rst_n=0.
- Load condition: load = ~out_valid | out_ready. The output register can take a new beat this cycle.
- Grant: combinational. Among channels with in_valid set, grant the first one found searching upward from ptr, wrapping n-1 -> 0. If no channel is valid, there is no grant.
  - Example, n=4, ptr=2: search order is 2, 3, 0, 1.
- in_ready[g] = load & grant_valid when g is the granted channel; all other in_ready bits are 0.
  - in_ready depends on in_valid. This is allowed; in_valid must not depend on in_ready.
- Transfer on input g (in_valid[g] & in_ready[g] at a clk edge):
  - out_data <= in_data[g*size +: size]
  - out_chan <= g
  - out_valid <= 1
  - ptr <= (g==n-1) ? 0 : g+1
- Output handshake:
  - out_valid & out_ready with no new transfer: out_valid <= 0, and out_data/out_chan hold their values.
  - Simultaneous drain and refill in the same cycle: the new beat replaces the old one, out_valid stays 1, no bubble.
- Backpressure: out_valid=1 and out_ready=0 means load=0.
  - All in_ready are 0.
  - out_data and out_chan stay stable.
  - ptr does not change.
- Idle: ptr changes only on a transfer. Idle cycles do not rotate priority.
- Fairness:
  - With all n channels continuously valid and out_ready=1, the grants cycle 0,1,...,n-1,0,...
  - Any continuously valid channel is granted within n transfers.
- Data is passed unmodified; there is no width conversion. Bits of in_data belonging to invalid channels are ignored.
- in_valid may drop without a transfer. The arbiter re-evaluates the grant every cycle and does not lock onto a channel.
- Reset while a beat is held or while backpressure is active: the beat is lost, ptr returns to 0, and the first grant after reset goes to the lowest valid index.
- The block never asserts X on in_ready or out_valid, even when in_valid is all zero.

Decomposition:
- Shared package holds the default width constant (16) shared with mux2, and a clog2 helper function if the toolflow lacks $clog2.
- The round-robin grant logic is a natural sub-module: rr_arbiter.
  - Inputs: req[n], ptr[chw].
  - Outputs: gnt_idx[chw], gnt_valid.
  - Purely combinational and reusable for bus arbitration elsewhere.
- The output register, ptr register and handshake logic stay in mux_rr_arb.

Test Plan (n=4, size=16 unless stated):
- Reset then idle: rst_n=0 for 2 cycles, then 1, with in_valid=0 -> out_valid=0, out_data=0, in_ready=0000, and ptr stays 0 for 10 cycles.
- Single channel: in_valid=0100, ch2 data=16'hBEEF, out_ready=1 -> in_ready=0100; next cycle out_valid=1, out_data=BEEF, out_chan=2; then ptr=3.
- Full contention: in_valid=1111 for 8 cycles, out_ready=1, ch i data=16'h00A0+i -> out_chan sequence 0,1,2,3,0,1,2,3 and out_data A0..A3 repeating, one beat per cycle, no bubbles.
- Backpressure: a beat from ch1 is held, out_ready=0 for 3 cycles, in_valid=1111 -> in_ready=0000, and out_data/out_chan stay stable. When out_ready goes to 1, the next grant is ch2 and the refill happens in the same cycle with out_valid staying 1.
- Reset mid-operation: out_valid=1 with ptr=3, assert rst_n=0 for 1 cycle with in_valid=1111 -> out_valid=0 after the edge; after release the first grant is ch0.
- Parameter sweep: n=2, size=8 and n=5, size=32 with random valid/ready for 10k cycles. A scoreboard checks:
  - beats are neither lost nor duplicated
  - per-channel order is preserved
  - wait time is ≤ n transfers
